// File: rtl/prog_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a synchronous program memory and
// hands each word to decode over valid/ready. Optional wrap halt: FETCH_WRAP_HALT_EN.
module prog_fetch_unit #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 8,
  parameter int                OPC_W    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [ADDR_W-1:0]       load_addr,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_rd,
  input  logic [DATA_W-1:0]       mem_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       program_byte,
  output logic [OPC_W-1:0]        instr,
  output logic [DATA_W-OPC_W-1:0] oprnd,
  output logic [ADDR_W-1:0]       pc
`ifdef FETCH_WRAP_HALT_EN
  ,
  output logic                    wrap_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_VALID
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_program_byte;
  logic                w_halt;

`ifdef FETCH_WRAP_HALT_EN
  logic r_wrap_err;
  logic w_pc_max;

  assign w_pc_max = &r_pc;
  assign w_halt   = r_wrap_err;
  assign wrap_err = r_wrap_err;

  // Sticky until a jump re-arms the unit; blocks new fetches while set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap_err <= 1'b0;
    end else if (load) begin
      r_wrap_err <= 1'b0;
    end else if ((r_state == S_CAPTURE) && w_pc_max) begin
      r_wrap_err <= 1'b1;
    end
  end
`else
  assign w_halt = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (load) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:    if (enable && !w_halt) w_next = S_FETCH;
        S_FETCH:   w_next = S_CAPTURE;
        S_CAPTURE: w_next = S_VALID;
        S_VALID:   if (out_ready) w_next = (enable && !w_halt) ? S_FETCH : S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // A jump wins over capture: the word read for the old stream is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc           <= RESET_PC;
      r_program_byte <= '0;
    end else if (load) begin
      r_pc           <= load_addr;
    end else if (r_state == S_CAPTURE) begin
      r_program_byte <= mem_data;
      r_pc           <= r_pc + 1'b1;
    end
  end

  assign mem_addr     = r_pc;
  assign mem_rd       = (r_state == S_FETCH);
  assign out_valid    = (r_state == S_VALID);
  assign program_byte = r_program_byte;
  assign instr        = r_program_byte[DATA_W-1 -: OPC_W];
  assign oprnd        = r_program_byte[DATA_W-OPC_W-1:0];
  assign pc           = r_pc;

endmodule

// File: tb/tb_prog_fetch_unit.sv
// Bench for prog_fetch_unit: ROM model, accepted-word scoreboard, jump vector table
// and hand-written back-pressure / flush / enable-drop / wrap / reset sequences.
module tb_prog_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [11:0] load_addr;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data = 8'h00;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  program_byte;
  logic [3:0]  instr;
  logic [3:0]  oprnd;
  logic [11:0] pc;
`ifdef FETCH_WRAP_HALT_EN
  logic        wrap_err;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] sbq[$];
  logic [7:0] rom [0:4095];

  typedef struct {
    logic [11:0] a;
    logic [7:0]  w;
    logic [3:0]  op;
    logic [3:0]  od;
    logic [11:0] npc;
  } vec_t;
  vec_t tbl[3];

  prog_fetch_unit #(.ADDR_W(12), .DATA_W(8), .OPC_W(4), .RESET_PC(12'h000)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_addr(load_addr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .program_byte(program_byte),
    .instr(instr), .oprnd(oprnd), .pc(pc)
`ifdef FETCH_WRAP_HALT_EN
    , .wrap_err(wrap_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_data <= rom[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!out_valid && k < 20) begin
      nc();
      k++;
    end
    if (!out_valid) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: out_valid got 0 expected 1 within 20 cycles", name);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    nc();
    reset = 1'b0;
  endtask

  // Scoreboard: each accepted handshake must deliver the next expected word.
  always begin
    @(negedge clk);
    #3;
    if (!reset && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_word", {24'h0, program_byte}, 32'hFFFF_FFFF);
      end else begin
        chk("sb_word", {24'h0, program_byte}, {24'h0, sbq.pop_front()});
      end
    end
  end

  initial begin
    int nv, first, last;
    for (int i = 0; i < 4096; i++) rom[i] = 8'(i) ^ 8'h5A;
    rom[12'h000] = 8'hA5; rom[12'h001] = 8'h3C; rom[12'h002] = 8'hF0;
    rom[12'h100] = 8'h42; rom[12'h101] = 8'h17; rom[12'h102] = 8'hD8;
    rom[12'h7AB] = 8'h9E; rom[12'h055] = 8'h61; rom[12'hFFF] = 8'hC7;
    tbl[0] = '{12'h7AB, 8'h9E, 4'h9, 4'hE, 12'h7AC};
    tbl[1] = '{12'h055, 8'h61, 4'h6, 4'h1, 12'h056};
    tbl[2] = '{12'hFFF, 8'hC7, 4'hC, 4'h7, 12'h000};

    reset = 1'b1; enable = 1'b0; load = 1'b0; load_addr = '0; out_ready = 1'b1;
    nc(); nc();
    chk("reset_state", {out_valid, mem_rd, pc, program_byte}, {1'b0, 1'b0, 12'h000, 8'h00});
    reset = 1'b0;
    nc();

    // Streaming three words with decode always ready
    sbq.push_back(8'hA5); sbq.push_back(8'h3C); sbq.push_back(8'hF0);
    enable = 1'b1;
    nv = 0; first = 0; last = 0;
    for (int c = 1; c <= 12; c++) begin
      nc();
      if (out_valid) begin
        nv++;
        if (nv == 1) begin
          first = c;
          chk("first_instr", instr, 4'hA);
          chk("first_oprnd", oprnd, 4'h5);
        end else begin
          chk("valid_period", c - last, 3);
        end
        last = c;
        if (nv == 3) enable = 1'b0;
      end
    end
    chk("first_latency", first, 3);
    chk("stream_count", nv, 3);
    chk("stream_end_idle", {out_valid, mem_rd, pc}, {1'b0, 1'b0, 12'h003});

    // Back-pressure hold, then flush by a jump during CAPTURE of address 2
    pulse_reset();
    out_ready = 1'b0;
    enable = 1'b1;
    sbq.push_back(8'hA5);
    wait_valid("bp_wait");
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {out_valid, mem_rd, pc, mem_addr, program_byte},
          {1'b1, 1'b0, 12'h001, 12'h001, 8'hA5});
      nc();
    end
    out_ready = 1'b1;
    sbq.push_back(8'h3C);
    nc();
    chk("bp_next_fetch", {mem_rd, mem_addr}, {1'b1, 12'h001});
    nc(); nc(); nc();
    chk("fetch_addr2", {mem_rd, mem_addr}, {1'b1, 12'h002});
    nc();
    chk("capture_addr2", {mem_rd, out_valid}, {1'b0, 1'b0});
    load = 1'b1; load_addr = 12'h100;
    nc();
    chk("flush_state", {out_valid, pc, program_byte}, {1'b0, 12'h100, 8'h3C});
    load = 1'b0;
    sbq.push_back(8'h42);
    wait_valid("flush_wait");
    chk("flush_word", {pc, program_byte}, {12'h101, 8'h42});

    // enable dropped during FETCH: word still delivered, then idle
    nc();
    chk("drop_fetch", {mem_rd, mem_addr}, {1'b1, 12'h101});
    enable = 1'b0;
    sbq.push_back(8'h17);
    wait_valid("drop_wait");
    chk("drop_word", program_byte, 8'h17);
    nc();
    for (int i = 0; i < 4; i++) begin
      chk("drop_idle", {mem_rd, out_valid, pc}, {1'b0, 1'b0, 12'h102});
      nc();
    end
    enable = 1'b1;
    sbq.push_back(8'hD8);
    wait_valid("resume_wait");
    chk("resume_pc", pc, 12'h103);
    enable = 1'b0;
    nc();

    // Jump vector table, last entry exercises the PC wrap
    for (int t = 0; t < 3; t++) begin
      load = 1'b1; load_addr = tbl[t].a;
      nc();
      load = 1'b0;
      chk("jump_pc", pc, {20'h0, tbl[t].a});
      enable = 1'b1;
      sbq.push_back(tbl[t].w);
      wait_valid("jump_wait");
      chk("jump_fields", {instr, oprnd, pc}, {tbl[t].op, tbl[t].od, tbl[t].npc});
      enable = 1'b0;
      nc();
    end

`ifdef FETCH_WRAP_HALT_EN
    chk("wrap_err_set", wrap_err, 1'b1);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nc();
      chk("wrap_halted", {out_valid, mem_rd}, 2'b00);
    end
    load = 1'b1; load_addr = 12'h000;
    nc();
    load = 1'b0;
    chk("wrap_err_clear", wrap_err, 1'b0);
`else
    enable = 1'b1;
`endif
    sbq.push_back(8'hA5);
    wait_valid("wrap_resume_wait");
    chk("wrap_resume_pc", {pc, program_byte}, {12'h001, 8'hA5});
    enable = 1'b0;
    nc();

    // Asynchronous reset while stalled in VALID
    pulse_reset();
    out_ready = 1'b0;
    enable = 1'b1;
    wait_valid("stall_wait");
    nc();
    chk("stall_before_reset", {out_valid, program_byte}, {1'b1, 8'hA5});
    reset = 1'b1;
    #1;
    chk("async_reset", {out_valid, mem_rd, pc, program_byte}, {1'b0, 1'b0, 12'h000, 8'h00});
    nc();
    reset = 1'b0; enable = 1'b0;
    nc();
    chk("sb_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
